// File: rtl/rpn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rpn_sequencer
//  Description : Reverse-Polish token sequencer. Turns number/operator tokens
//                into single-cycle push/pop commands for an external
//                registered stack and computes operator results from the
//                stack head. Halts with a sticky error on underflow/overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module rpn_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_kind,
  input  logic [W-1:0] tok_data,
  output logic [3:0]   stk_op,
  output logic [W-1:0] stk_in,
  output logic         stk_apply,
  input  logic [W-1:0] stk_head,
  input  logic         stk_empty,
  input  logic         stk_valid,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         err,
  output logic         busy
);

  localparam logic [3:0] OP_PUSH = 4'd0;
  localparam logic [3:0] OP_POP  = 4'd1;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PUSH_NUM = 4'd1,
    S_SETTLE_N = 4'd2,
    S_CHK_B    = 4'd3,
    S_POP_B    = 4'd4,
    S_CHK_A    = 4'd5,
    S_POP_A    = 4'd6,
    S_PUSH_RES = 4'd7,
    S_SETTLE_R = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  state_t       state_q;
  logic [1:0]   opc_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         stk_apply_q;
  logic [3:0]   stk_op_q;
  logic [W-1:0] stk_in_q;
  logic [W-1:0] result_q;
  logic         result_valid_q;
  logic         err_q;
  logic [W-1:0] alu_d;

  // Operator arithmetic on latched operands; a is second-from-top, b is top.
  always_comb begin
    alu_d = '0;
    unique case (opc_q)
      2'b00:   alu_d = a_q + b_q;
      2'b01:   alu_d = a_q - b_q;
      2'b10:   alu_d = a_q * b_q;
      default: alu_d = a_q ^ b_q;
    endcase
  end

  // Sequencer FSM with registered stack command, result and error outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      opc_q          <= 2'b00;
      a_q            <= '0;
      b_q            <= '0;
      stk_apply_q    <= 1'b0;
      stk_op_q       <= 4'd0;
      stk_in_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // Strobes default low so each command lasts exactly one cycle.
      stk_apply_q    <= 1'b0;
      stk_op_q       <= 4'd0;
      stk_in_q       <= '0;
      result_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (tok_valid) begin
            if (!tok_kind) begin
              state_q     <= S_PUSH_NUM;
              stk_apply_q <= 1'b1;
              stk_op_q    <= OP_PUSH;
              stk_in_q    <= tok_data;
            end else begin
              opc_q   <= tok_data[1:0];
              state_q <= S_CHK_B;
            end
          end
        end
        S_PUSH_NUM: state_q <= S_SETTLE_N;
        S_SETTLE_N: begin
          if (!stk_valid) begin
            state_q <= S_HALT;
            err_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CHK_B: begin
          if (stk_empty) begin
            state_q <= S_HALT;
            err_q   <= 1'b1;
          end else begin
            b_q         <= stk_head;
            state_q     <= S_POP_B;
            stk_apply_q <= 1'b1;
            stk_op_q    <= OP_POP;
          end
        end
        S_POP_B: state_q <= S_CHK_A;
        S_CHK_A: begin
          // b has already been popped; on underflow it is deliberately lost.
          if (stk_empty) begin
            state_q <= S_HALT;
            err_q   <= 1'b1;
          end else begin
            a_q         <= stk_head;
            state_q     <= S_POP_A;
            stk_apply_q <= 1'b1;
            stk_op_q    <= OP_POP;
          end
        end
        S_POP_A: begin
          state_q     <= S_PUSH_RES;
          stk_apply_q <= 1'b1;
          stk_op_q    <= OP_PUSH;
          stk_in_q    <= alu_d;
        end
        S_PUSH_RES: state_q <= S_SETTLE_R;
        S_SETTLE_R: begin
          if (!stk_valid) begin
            state_q <= S_HALT;
            err_q   <= 1'b1;
          end else begin
            result_q       <= alu_d;
            result_valid_q <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tok_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign stk_apply    = stk_apply_q;
  assign stk_op       = stk_op_q;
  assign stk_in       = stk_in_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rpn_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rpn_sequencer
//  Description : Directed self-checking bench for rpn_sequencer with a small
//                registered stack model (depth 4) attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rpn_sequencer;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst;
  logic         tok_valid;
  logic         tok_ready;
  logic         tok_kind;
  logic [W-1:0] tok_data;
  logic [3:0]   stk_op;
  logic [W-1:0] stk_in;
  logic         stk_apply;
  logic [W-1:0] stk_head;
  logic         stk_empty;
  logic         stk_valid;
  logic [W-1:0] result;
  logic         result_valid;
  logic         err;
  logic         busy;

  rpn_sequencer #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_kind     (tok_kind),
    .tok_data     (tok_data),
    .stk_op       (stk_op),
    .stk_in       (stk_in),
    .stk_apply    (stk_apply),
    .stk_head     (stk_head),
    .stk_empty    (stk_empty),
    .stk_valid    (stk_valid),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered stack model: commands show up on the outputs one cycle later.
  logic         stk_rst;
  logic [W-1:0] mem [DEPTH];
  int           sp;
  logic         sv;
  always @(posedge clk) begin
    if (stk_rst) begin
      sp <= 0;
      sv <= 1'b1;
    end else if (stk_apply) begin
      if (stk_op == 4'd0) begin
        if (sp == DEPTH) sv <= 1'b0;
        else begin
          mem[sp] <= stk_in;
          sp      <= sp + 1;
          sv      <= 1'b1;
        end
      end else begin
        if (sp == 0) sv <= 1'b0;
        else begin
          sp <= sp - 1;
          sv <= 1'b1;
        end
      end
    end
  end
  assign stk_head  = (sp > 0) ? mem[sp-1] : '0;
  assign stk_empty = (sp == 0);
  assign stk_valid = sv;

  // Activity monitor sampled on the falling edge.
  logic         mon_clr;
  int           apply_cnt;
  logic [31:0]  op_hist;
  logic [W-1:0] last_in;
  int           rv_cnt;
  int           rv_cyc;
  logic [W-1:0] last_res;
  logic         err_seen;
  int           err_cyc;
  always @(negedge clk) begin
    if (mon_clr) begin
      apply_cnt = 0;
      op_hist   = 32'd0;
      last_in   = '0;
      rv_cnt    = 0;
      rv_cyc    = -1;
      last_res  = '0;
      err_seen  = 1'b0;
      err_cyc   = -1;
    end else begin
      if (stk_apply) begin
        apply_cnt = apply_cnt + 1;
        op_hist   = (op_hist << 4) | {28'd0, stk_op};
        last_in   = stk_in;
      end
      if (result_valid) begin
        rv_cnt   = rv_cnt + 1;
        rv_cyc   = cyc;
        last_res = result;
      end
      if (err && !err_seen) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int xfer_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mon_clr   = 1'b1;
    rst       = 1'b0;
    stk_rst   = 1'b1;
    tok_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    stk_rst = 1'b0;
    mon_clr = 1'b0;
  endtask

  // Present one token and hold it until it is transferred (bounded wait).
  task automatic send_tok(input logic kind, input logic [W-1:0] data);
    int n;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_kind  = kind;
    tok_data  = data;
    n = 0;
    while (!tok_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      check_eq("tok_accept_timeout", 32'd0, 32'd1);
      tok_valid = 1'b0;
    end else begin
      xfer_cyc = cyc;
      @(posedge clk);
      #1;
      tok_valid = 1'b0;
      tok_kind  = ~kind;
      tok_data  = 8'hA5;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] opc, input logic [W-1:0] exp);
    do_reset();
    send_tok(1'b0, a);
    send_tok(1'b0, b);
    send_tok(1'b1, {6'd0, opc});
    repeat (9) @(negedge clk);
    check_eq({tag, "_result"}, {24'd0, last_res}, {24'd0, exp});
    check_eq({tag, "_rv_cnt"}, rv_cnt, 32'd1);
    check_eq({tag, "_head"}, {24'd0, stk_head}, {24'd0, exp});
  endtask

  initial begin
    rst       = 1'b1;
    stk_rst   = 1'b1;
    mon_clr   = 1'b1;
    tok_valid = 1'b0;
    tok_kind  = 1'b0;
    tok_data  = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_tok_ready", {31'd0, tok_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_apply", {31'd0, stk_apply}, 32'd0);
    check_eq("rst_result", {24'd0, result}, 32'd0);
    check_eq("rst_rv", {31'd0, result_valid}, 32'd0);

    // 22 5 sub
    send_tok(1'b0, 8'd22);
    @(negedge clk);
    check_eq("num_busy", {31'd0, busy}, 32'd1);
    send_tok(1'b0, 8'd5);
    send_tok(1'b1, 8'd1);
    repeat (9) @(negedge clk);
    check_eq("sub_apply_cnt", apply_cnt, 32'd5);
    check_eq("sub_op_seq", op_hist, 32'h0000_0110);
    check_eq("sub_last_push", {24'd0, last_in}, 32'd17);
    check_eq("sub_result", {24'd0, last_res}, 32'd17);
    check_eq("sub_rv_cnt", rv_cnt, 32'd1);
    check_eq("sub_rv_latency", rv_cyc - xfer_cyc, 32'd7);
    check_eq("sub_head", {24'd0, stk_head}, 32'd17);
    check_eq("sub_empty", {31'd0, stk_empty}, 32'd0);
    check_eq("sub_err", {31'd0, err}, 32'd0);

    // Wrap-around
    run_op("add", 8'd200, 8'd100, 2'b00, 8'd44);
    run_op("mul", 8'd16, 8'd16, 2'b10, 8'd0);
    run_op("xor", 8'd3, 8'd5, 2'b11, 8'd6);
    run_op("subwrap", 8'd3, 8'd5, 2'b01, 8'd254);

    // Underflow with a lone number
    do_reset();
    send_tok(1'b0, 8'd3);
    send_tok(1'b1, 8'd0);
    repeat (8) @(negedge clk);
    check_eq("lone_err", {31'd0, err}, 32'd1);
    check_eq("lone_tok_ready", {31'd0, tok_ready}, 32'd0);
    check_eq("lone_op_seq", op_hist, 32'h0000_0001);
    repeat (10) @(negedge clk);
    check_eq("lone_apply_cnt", apply_cnt, 32'd2);
    check_eq("lone_rv_cnt", rv_cnt, 32'd0);
    check_eq("lone_tok_ready_late", {31'd0, tok_ready}, 32'd0);

    // Underflow on an empty stack
    do_reset();
    send_tok(1'b1, 8'd2);
    repeat (4) @(negedge clk);
    check_eq("empty_err", {31'd0, err}, 32'd1);
    check_eq("empty_err_cycle", err_cyc - xfer_cyc, 32'd2);
    check_eq("empty_apply_cnt", apply_cnt, 32'd0);

    // Overflow: fifth push into a depth-4 stack
    do_reset();
    send_tok(1'b0, 8'd1);
    send_tok(1'b0, 8'd2);
    send_tok(1'b0, 8'd3);
    send_tok(1'b0, 8'd4);
    repeat (3) @(negedge clk);
    check_eq("ovf_err_before", {31'd0, err}, 32'd0);
    send_tok(1'b0, 8'd5);
    repeat (4) @(negedge clk);
    check_eq("ovf_err", {31'd0, err}, 32'd1);
    check_eq("ovf_busy", {31'd0, busy}, 32'd1);
    check_eq("ovf_tok_ready", {31'd0, tok_ready}, 32'd0);
    check_eq("ovf_apply_cnt", apply_cnt, 32'd5);

    // Reset asserted during POP_A
    do_reset();
    send_tok(1'b0, 8'd1);
    send_tok(1'b0, 8'd2);
    send_tok(1'b1, 8'd0);
    repeat (4) @(negedge clk);
    check_eq("mid_popa_apply", {31'd0, stk_apply}, 32'd1);
    check_eq("mid_popa_op", {28'd0, stk_op}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_tok_ready", {31'd0, tok_ready}, 32'd1);
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_apply", {31'd0, stk_apply}, 32'd0);
    check_eq("mid_err", {31'd0, err}, 32'd0);
    repeat (8) @(negedge clk);
    check_eq("mid_rv_cnt", rv_cnt, 32'd0);
    send_tok(1'b0, 8'd9);
    repeat (4) @(negedge clk);
    check_eq("mid_after_head", {24'd0, stk_head}, 32'd9);
    check_eq("mid_after_err", {31'd0, err}, 32'd0);
    check_eq("mid_after_ready", {31'd0, tok_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
